// File: rtl/uart_frame_parser.sv
// uart_frame_parser: hunts SOF/LEN/payload/CHK frames in a UART byte stream,
// holds good frames for random-access reads and flags bad ones with a cause.
module uart_frame_parser #(
    parameter int          MAX_LEN      = 16,
    parameter logic [7:0]  SOF          = 8'hAA,
    parameter int          TIMEOUT_CLKS = 104160,
    localparam int         LW           = $clog2(MAX_LEN + 1),
    localparam int         AW           = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_done,
    output logic          frame_valid,
    output logic [LW-1:0] frame_len,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    input  logic          frame_ack,
    output logic          frame_err,
    output logic [1:0]    err_code
);

    localparam int TW = $clog2(TIMEOUT_CLKS);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CLKS - 1);

    localparam logic [1:0] ERR_LEN = 2'd0;
    localparam logic [1:0] ERR_CHK = 2'd1;
    localparam logic [1:0] ERR_TMO = 2'd2;
    localparam logic [1:0] ERR_OVR = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_HOLD
    } state_t;

    state_t        state_q, state_d;
    logic          rx_done_q;
    logic          stb;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [7:0]    chk_q, chk_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;
    logic          valid_q, valid_d;
    logic [LW-1:0] flen_q, flen_d;
    logic          wr_en;
    logic          len_ok;
    logic          active;
    logic [7:0]    mem [MAX_LEN];

    assign stb    = rx_done & ~rx_done_q;
    assign len_ok = (rx_data != 8'd0) && (rx_data <= 8'(MAX_LEN));
    assign active = (state_q == S_LEN) || (state_q == S_PAYLOAD)
                 || (state_q == S_CHK);

    // Registered state, counters and outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            rx_done_q <= 1'b1;
            len_q     <= '0;
            cnt_q     <= '0;
            chk_q     <= '0;
            tcnt_q    <= '0;
            err_q     <= 1'b0;
            code_q    <= 2'd0;
            valid_q   <= 1'b0;
            flen_q    <= '0;
        end else begin
            state_q   <= state_d;
            rx_done_q <= rx_done;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            chk_q     <= chk_d;
            tcnt_q    <= tcnt_d;
            err_q     <= err_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            flen_q    <= flen_d;
        end
    end

    // Next-state, datapath updates and error causes.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        chk_d   = chk_q;
        tcnt_d  = '0;
        err_d   = 1'b0;
        code_d  = code_q;
        valid_d = valid_q;
        flen_d  = flen_q;
        wr_en   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (stb && rx_data == SOF) state_d = S_LEN;
            end
            S_LEN: begin
                if (stb) begin
                    if (len_ok) begin
                        len_d   = rx_data[LW-1:0];
                        cnt_d   = '0;
                        chk_d   = rx_data;
                        state_d = S_PAYLOAD;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_LEN;
                        state_d = S_IDLE;
                    end
                end
            end
            S_PAYLOAD: begin
                if (stb) begin
                    wr_en = 1'b1;
                    chk_d = chk_q ^ rx_data;
                    cnt_d = cnt_q + LW'(1);
                    if (cnt_d == len_q) state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (stb) begin
                    if (rx_data == chk_q) begin
                        valid_d = 1'b1;
                        flen_d  = len_q;
                        state_d = S_HOLD;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_CHK;
                        state_d = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                if (frame_ack) begin
                    valid_d = 1'b0;
                    flen_d  = '0;
                    state_d = (stb && rx_data == SOF) ? S_LEN : S_IDLE;
                end else if (stb) begin
                    err_d  = 1'b1;
                    code_d = ERR_OVR;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A strobe in the expiry cycle wins over the timeout.
        if (active && !stb) begin
            if (tcnt_q == TLAST) begin
                err_d   = 1'b1;
                code_d  = ERR_TMO;
                state_d = S_IDLE;
            end else begin
                tcnt_d = tcnt_q + TW'(1);
            end
        end
    end

    // Payload buffer; not reset, reads are masked by frame_len.
    always_ff @(posedge clk) begin
        if (wr_en) mem[cnt_q[AW-1:0]] <= rx_data;
    end

    assign rd_data     = (LW'(rd_addr) < flen_q) ? mem[rd_addr] : 8'h00;
    assign frame_valid = valid_q;
    assign frame_len   = flen_q;
    assign frame_err   = err_q;
    assign err_code    = code_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: scoreboard bench for uart_frame_parser.
// Expected frame/error events are queued before the triggering byte is sent.
module tb_uart_frame_parser;

    localparam int TO = 40;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       frame_valid;
    logic [4:0] frame_len;
    logic [3:0] rd_addr = 4'd0;
    logic [7:0] rd_data;
    logic       frame_ack = 1'b0;
    logic       frame_err;
    logic [1:0] err_code;

    int n_checks = 0;
    int n_errs   = 0;

    typedef struct {
        bit         is_err;
        logic [1:0] code;
        logic [4:0] len;
    } ev_t;

    ev_t sbq[$];
    bit  vprev = 1'b0;

    uart_frame_parser #(
        .MAX_LEN(16),
        .SOF(8'hAA),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rx_data(rx_data),
        .rx_done(rx_done),
        .frame_valid(frame_valid),
        .frame_len(frame_len),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .frame_ack(frame_ack),
        .frame_err(frame_err),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Scoreboard: every error pulse cycle and every frame_valid rise pops one event.
    always @(negedge clk) begin
        ev_t e;
        if (reset_n && (frame_err || (frame_valid && !vprev))) begin
            n_checks++;
            if (sbq.size() == 0) begin
                n_errs++;
                $display("FAIL unexpected_event: err=%0b code=%0d valid=%0b len=%0d, required none",
                         frame_err, err_code, frame_valid, frame_len);
            end else begin
                e = sbq.pop_front();
                if (frame_err !== e.is_err
                    || (e.is_err && err_code !== e.code)
                    || (!e.is_err && frame_len !== e.len)) begin
                    n_errs++;
                    $display("FAIL event: got err=%0b code=%0d len=%0d, required err=%0b code=%0d len=%0d",
                             frame_err, err_code, frame_len, e.is_err, e.code, e.len);
                end
            end
        end
        vprev = reset_n ? frame_valid : 1'b0;
    end

    task automatic push_err(input logic [1:0] c);
        ev_t e;
        e.is_err = 1'b1; e.code = c; e.len = 5'd0;
        sbq.push_back(e);
    endtask

    task automatic push_frame(input logic [4:0] l);
        ev_t e;
        e.is_err = 1'b0; e.code = 2'd0; e.len = l;
        sbq.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic check_rd(input logic [3:0] a, input logic [7:0] exp, input string nm);
        rd_addr = a;
        #1;
        n_checks++;
        if (rd_data !== exp) begin
            n_errs++;
            $display("FAIL %s: rd_data[%0d]=%h, required %h", nm, a, rd_data, exp);
        end
    endtask

    task automatic check_valid(input logic exp, input string nm);
        n_checks++;
        if (frame_valid !== exp) begin
            n_errs++;
            $display("FAIL %s: frame_valid=%0b, required %0b", nm, frame_valid, exp);
        end
    endtask

    task automatic do_ack();
        @(negedge clk);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        check_valid(1'b0, "ack_release");
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rx_done = 1'b1;
        rx_data = 8'hAA;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (frame_valid !== 1'b0 || frame_err !== 1'b0 || frame_len !== 5'd0) begin
            n_errs++;
            $display("FAIL reset: valid=%0b err=%0b len=%0d, required 0 0 0",
                     frame_valid, frame_err, frame_len);
        end
        check_rd(4'd0, 8'h00, "reset_rd");
        rx_done = 1'b0;
        // A stray AA from reset would make the next frame's AA a bad LEN.
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'hAA);
        send_byte(8'h03);
        send_byte(8'h11);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (frame_valid !== 1'b0 || frame_err !== 1'b0 || frame_len !== 5'd0) begin
            n_errs++;
            $display("FAIL reset_mid: valid=%0b err=%0b len=%0d, required 0 0 0",
                     frame_valid, frame_err, frame_len);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_good_frame();
        send_byte(8'hAA);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        push_frame(5'd3);
        send_byte(8'h03);
        check_valid(1'b1, "good_valid");
        check_rd(4'd0, 8'h11, "good_rd0");
        check_rd(4'd1, 8'h22, "good_rd1");
        check_rd(4'd2, 8'h33, "good_rd2");
        check_rd(4'd3, 8'h00, "good_rd3");
        do_ack();
    endtask

    task automatic test_checksum();
        send_byte(8'hAA);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        push_err(2'd1);
        send_byte(8'h04);
        check_valid(1'b0, "chk_no_valid");
        send_byte(8'hAA);
        send_byte(8'h01);
        send_byte(8'h5A);
        push_frame(5'd1);
        send_byte(8'h01 ^ 8'h5A);
        check_valid(1'b1, "recover_valid");
        check_rd(4'd0, 8'h5A, "recover_rd0");
        do_ack();
    endtask

    task automatic test_bad_length();
        send_byte(8'hAA);
        push_err(2'd0);
        send_byte(8'h00);
        send_byte(8'hAA);
        push_err(2'd0);
        send_byte(8'h11);
        send_byte(8'h55);
        repeat (4) @(negedge clk);
        check_valid(1'b0, "badlen_idle");
    endtask

    task automatic test_timeout();
        int k;
        bit seen;
        send_byte(8'hAA);
        send_byte(8'h02);
        push_err(2'd2);
        send_byte(8'h7E);
        k = 0;
        seen = 1'b0;
        while (!seen && k < 3 * TO) begin
            @(negedge clk);
            k++;
            if (frame_err) seen = 1'b1;
        end
        n_checks++;
        if (!seen || k != TO) begin
            n_errs++;
            $display("FAIL timeout: seen=%0b after %0d cycles, required 1 after %0d",
                     seen, k, TO);
        end
        // Strobe exactly in the expiry cycle.
        send_byte(8'hAA);
        send_byte(8'h02);
        send_byte(8'h7E);
        repeat (TO - 2) @(negedge clk);
        send_byte(8'h81);
        push_frame(5'd2);
        send_byte(8'h02 ^ 8'h7E ^ 8'h81);
        check_valid(1'b1, "tmo_suppressed");
        do_ack();
    endtask

    task automatic test_overrun_ack_sof();
        send_byte(8'hAA);
        send_byte(8'h02);
        send_byte(8'hC3);
        send_byte(8'h3C);
        push_frame(5'd2);
        send_byte(8'h02 ^ 8'hC3 ^ 8'h3C);
        push_err(2'd3);
        send_byte(8'h55);
        check_valid(1'b1, "ovr_still_valid");
        check_rd(4'd0, 8'hC3, "ovr_rd0");
        check_rd(4'd1, 8'h3C, "ovr_rd1");
        @(negedge clk);
        rx_data = 8'hAA;
        rx_done = 1'b1;
        frame_ack = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        frame_ack = 1'b0;
        check_valid(1'b0, "ack_sof_release");
        send_byte(8'h01);
        send_byte(8'h09);
        push_frame(5'd1);
        send_byte(8'h01 ^ 8'h09);
        check_valid(1'b1, "ack_sof_frame");
        check_rd(4'd0, 8'h09, "ack_sof_rd0");
        do_ack();
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_reset_mid_frame();
        test_checksum();
        test_bad_length();
        test_timeout();
        test_overrun_ack_sof();
        repeat (3) @(negedge clk);
        n_checks++;
        if (sbq.size() != 0) begin
            n_errs++;
            $display("FAIL missing_events: %0d pending, required 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
